// File: rtl/rast_tri_issuer_pkg.sv
// Shared rast triangle-interface parameters and payload types.
package rast_tri_issuer_pkg;

  localparam int unsigned SIGFIG      = 24;
  localparam int unsigned VERTS       = 3;
  localparam int unsigned AXIS        = 3;
  localparam int unsigned COLORS      = 3;
  localparam int unsigned ISSUE_DEPTH = 4;

  localparam int unsigned TRI_W   = SIGFIG * VERTS * AXIS;
  localparam int unsigned COLOR_W = SIGFIG * COLORS;

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          color_t;

  // One buffered triangle: vertex coordinates (signed words) and color.
  typedef struct packed {
    tri_t   vtx;
    color_t color;
  } tri_pkt_t;

  typedef enum logic {
    S_EMPTY  = 1'b0,
    S_LOADED = 1'b1
  } out_state_e;

endpackage

// File: rtl/rast_tri_fifo.sv
// Small synchronous FIFO of triangle packets sitting behind the issuer output stage.
module rast_tri_fifo
  import rast_tri_issuer_pkg::*;
#(
  parameter int unsigned ENTRIES = ISSUE_DEPTH - 1,
  localparam int unsigned AW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int unsigned CW     = $clog2(ENTRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  tri_pkt_t      wdata,
  input  logic          pop,
  output tri_pkt_t      rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  tri_pkt_t        mem [ENTRIES];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(ENTRIES));
  assign empty = (count == '0);

  // Payload storage; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap modulo ENTRIES; occupancy count gives full/empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(ENTRIES - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(ENTRIES - 1)) ? '0 : rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rast_tri_issuer.sv
// Buffers producer triangles and presents them to rast under halt backpressure.
module rast_tri_issuer
  import rast_tri_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_DEPTH,
  parameter int unsigned CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TRI_W-1:0]   in_tri,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               halt_RnnnnL,
  output tri_t               tri_R10S,
  output color_t             color_R10U,
  output logic               validTri_R10H,
  output logic [CNTW-1:0]    issued_cnt,
  output logic               idle
);

  localparam int unsigned FIFO_ENTRIES = DEPTH - 1;
  localparam int unsigned FCW          = $clog2(FIFO_ENTRIES + 1);
  localparam int unsigned OCCW         = $clog2(DEPTH + 1);

  out_state_e      state_q, state_d;
  tri_pkt_t        out_q;
  tri_pkt_t        in_pkt;
  tri_pkt_t        fifo_head;
  logic [FCW-1:0]  fifo_count;
  logic            fifo_full, fifo_empty;
  logic            push, xfer, slot_free, load, fifo_push, fifo_pop;
  logic [OCCW-1:0] occ, occ_next;

  assign in_pkt = {in_tri, in_color};

  // Handshakes and output-stage refill; an empty FIFO lets a push bypass into the output stage.
  assign push      = in_valid & in_ready;
  assign xfer      = validTri_R10H & halt_RnnnnL;
  assign slot_free = (state_q == S_EMPTY) | xfer;
  assign load      = slot_free & (~fifo_empty | push);
  assign fifo_pop  = slot_free & ~fifo_empty;
  assign fifo_push = push & ~(slot_free & fifo_empty) & ~fifo_full;

  // Total occupancy counts the output stage as one slot.
  assign occ      = OCCW'(fifo_count) + OCCW'(validTri_R10H);
  assign occ_next = occ + OCCW'(push) - OCCW'(xfer);
  assign idle     = (occ == '0);

  assign validTri_R10H = (state_q == S_LOADED);
  assign tri_R10S      = out_q.vtx;
  assign color_R10U    = out_q.color;

  rast_tri_fifo #(.ENTRIES(FIFO_ENTRIES)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_pkt),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  // Output-stage next state: hold while halted, refill or drain on transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY:  if (load) state_d = S_LOADED;
      S_LOADED: if (xfer) state_d = load ? S_LOADED : S_EMPTY;
      default:  state_d = S_EMPTY;
    endcase
  end

  // Output payload, registered ready and issued-triangle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      in_ready   <= 1'b0;
      issued_cnt <= '0;
    end else begin
      if (load) out_q <= fifo_empty ? in_pkt : fifo_head;
      in_ready <= (occ_next != OCCW'(DEPTH));
      if (xfer) issued_cnt <= issued_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_rast_tri_issuer.sv
// Randomized bench for rast_tri_issuer against a queue-based reference model.
module tb_rast_tri_issuer;
  import rast_tri_issuer_pkg::*;

  localparam int unsigned DEPTH = ISSUE_DEPTH;
  localparam int unsigned CNTW  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [TRI_W-1:0]   in_tri;
  logic [COLOR_W-1:0] in_color;
  logic               in_valid;
  logic               in_ready;
  logic               halt_RnnnnL;
  tri_t               tri_R10S;
  color_t             color_R10U;
  logic               validTri_R10H;
  logic [CNTW-1:0]    issued_cnt;
  logic               idle;

  rast_tri_issuer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_tri        (in_tri),
    .in_color      (in_color),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .halt_RnnnnL   (halt_RnnnnL),
    .tri_R10S      (tri_R10S),
    .color_R10U    (color_R10U),
    .validTri_R10H (validTri_R10H),
    .issued_cnt    (issued_cnt),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted, not-yet-transferred triangle in arrival order.
  tri_pkt_t        m_q[$];
  bit              m_ready;
  logic [CNTW-1:0] m_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  tri_pkt_t obs_pkt;
  assign obs_pkt = {tri_R10S, color_R10U};

  function automatic tri_pkt_t rand_pkt();
    logic [$bits(tri_pkt_t)-1:0] v;
    for (int i = 0; i < $bits(tri_pkt_t); i += 32) v[i+:32] = $urandom();
    return tri_pkt_t'(v);
  endfunction

  task automatic drive_pkt(input tri_pkt_t p);
    {in_tri, in_color} = p;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge, settle 1ns.
  task automatic tick();
    bit acc, xf;
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_ready = 1'b0;
      m_cnt   = '0;
    end else begin
      acc = in_valid && m_ready;
      xf  = (m_q.size() > 0) && halt_RnnnnL;
      if (xf) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + CNTW'(1);
      end
      if (acc) m_q.push_back(tri_pkt_t'({in_tri, in_color}));
      m_ready = (m_q.size() != DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; halt_RnnnnL = 1'b1;
    drive_pkt(rand_pkt());
    repeat (3) tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (validTri_R10H !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", validTri_R10H); end
    n_cmp++; if (issued_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", issued_cnt); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
    n_cmp++; if (obs_pkt !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", obs_pkt); end
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (validTri_R10H !== 1'b0) begin n_fail++; $display("FAIL release_valid got=%b exp=0", validTri_R10H); end
  endtask

  task automatic test_single();
    tri_pkt_t a;
    a = rand_pkt();
    drive_pkt(a); in_valid = 1'b1; halt_RnnnnL = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (validTri_R10H !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", validTri_R10H); end
    n_cmp++; if (obs_pkt !== a) begin n_fail++; $display("FAIL single_data got=%h exp=%h", obs_pkt, a); end
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b exp=0", idle); end
    tick();
    n_cmp++; if (validTri_R10H !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", validTri_R10H); end
    n_cmp++; if (issued_cnt !== CNTW'(1)) begin n_fail++; $display("FAIL single_cnt got=%0d exp=1", issued_cnt); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_stall();
    tri_pkt_t exp_list[$];
    tri_pkt_t held;
    int acc = 0;
    halt_RnnnnL = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_pkt(rand_pkt()); in_valid = 1'b1;
      if (in_ready && in_valid) begin
        acc++;
        exp_list.push_back(tri_pkt_t'({in_tri, in_color}));
      end
      tick();
      if (i == 0) held = obs_pkt;
      n_cmp++; if (validTri_R10H !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, validTri_R10H); end
      n_cmp++; if (obs_pkt !== held) begin n_fail++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs_pkt, held); end
    end
    in_valid = 1'b0;
    n_cmp++; if (acc != 4) begin n_fail++; $display("FAIL stall_accepted got=%0d exp=4", acc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full got=%b exp=0", in_ready); end
    halt_RnnnnL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (validTri_R10H !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, validTri_R10H); end
      n_cmp++; if (i < exp_list.size() && obs_pkt !== exp_list[i]) begin n_fail++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, obs_pkt, exp_list[i]); end
      tick();
    end
    n_cmp++; if (validTri_R10H !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", validTri_R10H); end
    n_cmp++; if (issued_cnt !== CNTW'(5)) begin n_fail++; $display("FAIL drain_cnt got=%0d exp=5", issued_cnt); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle got=%b exp=1", idle); end
  endtask

  task automatic test_stream();
    int pushes = 0, xfers = 0, cyc = 0, drops = 0, bad = 0;
    halt_RnnnnL = 1'b1;
    while (xfers < 100 && cyc < 300) begin
      if (pushes < 100) begin drive_pkt(rand_pkt()); in_valid = 1'b1; end
      else in_valid = 1'b0;
      if (in_valid && !in_ready) drops++;
      if (in_valid && in_ready) pushes++;
      if (validTri_R10H && halt_RnnnnL) begin
        xfers++;
        if (m_q.size() == 0 || obs_pkt !== m_q[0]) bad++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (xfers != 100) begin n_fail++; $display("FAIL stream_xfers got=%0d exp=100", xfers); end
    n_cmp++; if (cyc != 101) begin n_fail++; $display("FAIL stream_cycles got=%0d exp=101", cyc); end
    n_cmp++; if (drops != 0) begin n_fail++; $display("FAIL stream_ready_drop got=%0d exp=0", drops); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL stream_data got=%0d bad exp=0", bad); end
  endtask

  task automatic test_random();
    tri_pkt_t prev;
    bit hold;
    for (int i = 0; i < 400; i++) begin
      halt_RnnnnL = 1'($urandom_range(0, 1));
      in_valid    = ($urandom_range(0, 3) != 0);
      drive_pkt(rand_pkt());
      hold = validTri_R10H && !halt_RnnnnL;
      prev = obs_pkt;
      tick();
      n_cmp++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, m_ready); end
      n_cmp++; if (validTri_R10H !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, validTri_R10H, m_q.size() > 0); end
      n_cmp++; if (idle !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_idle[%0d] got=%b exp=%b", i, idle, m_q.size() == 0); end
      n_cmp++; if (issued_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, issued_cnt, m_cnt); end
      if (m_q.size() > 0) begin
        n_cmp++; if (obs_pkt !== m_q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, obs_pkt, m_q[0]); end
      end
      if (hold) begin
        n_cmp++; if (obs_pkt !== prev || validTri_R10H !== 1'b1) begin n_fail++; $display("FAIL rnd_hold[%0d] got=%h/%b exp=%h/1", i, obs_pkt, validTri_R10H, prev); end
      end
    end
  endtask

  task automatic test_reset_mid();
    tri_pkt_t b;
    int guard = 0;
    in_valid = 1'b0; halt_RnnnnL = 1'b1;
    while (!idle && guard < 20) begin tick(); guard++; end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_predrain got=%b exp=1", idle); end
    halt_RnnnnL = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_pkt(rand_pkt()); in_valid = 1'b1; tick(); end
    in_valid = 1'b0;
    n_cmp++; if (validTri_R10H !== 1'b1) begin n_fail++; $display("FAIL mid_loaded got=%b exp=1", validTri_R10H); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (validTri_R10H !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got=%b exp=0", validTri_R10H); end
    n_cmp++; if (obs_pkt !== '0) begin n_fail++; $display("FAIL mid_async_data got=%h exp=0", obs_pkt); end
    n_cmp++; if (issued_cnt !== '0) begin n_fail++; $display("FAIL mid_async_cnt got=%0d exp=0", issued_cnt); end
    n_cmp++; if (idle !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async_idle_ready got=%b/%b exp=1/0", idle, in_ready); end
    m_q.delete(); m_ready = 1'b0; m_cnt = '0;
    @(negedge clk) rst = 1'b1;
    tick();
    b = rand_pkt();
    drive_pkt(b); in_valid = 1'b1; halt_RnnnnL = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (obs_pkt !== b || validTri_R10H !== 1'b1) begin n_fail++; $display("FAIL mid_first got=%h/%b exp=%h/1", obs_pkt, validTri_R10H, b); end
    n_cmp++; if (issued_cnt !== '0) begin n_fail++; $display("FAIL mid_cnt0 got=%0d exp=0", issued_cnt); end
    tick();
    n_cmp++; if (issued_cnt !== CNTW'(1) || idle !== 1'b1) begin n_fail++; $display("FAIL mid_cnt1 got=%0d/%b exp=1/1", issued_cnt, idle); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; halt_RnnnnL = 1'b1; in_tri = '0; in_color = '0;
    m_ready = 1'b0; m_cnt = '0;
    test_reset();
    test_single();
    test_stall();
    test_stream();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
